// File: rtl/dl_demux_pkg.sv
// dl_demux_pkg
// Shared constants, types and the select decode for the demux family.
// Contents:
//   DL_DEMUX5_NUM_CH  - number of output channels of the 5-way demux
//   DL_DEMUX5_SEL_W   - width of the channel select
//   dl_sel_to_onehot  - select to one-hot decode; an out-of-range select
//                       decodes to all zeros so callers choose the fallback
package dl_demux_pkg;

  localparam int DL_DEMUX5_NUM_CH = 5;
  localparam int DL_DEMUX5_SEL_W  = 3;

  typedef logic [DL_DEMUX5_SEL_W-1:0]  dl_demux5_sel_t;
  typedef logic [DL_DEMUX5_NUM_CH-1:0] dl_demux5_vec_t;

  function automatic dl_demux5_vec_t dl_sel_to_onehot(input dl_demux5_sel_t sel);
    dl_demux5_vec_t onehot;
    onehot = 5'b00000;
    for (int k = 0; k < DL_DEMUX5_NUM_CH; k++) begin
      if (int'(sel) == k) begin
        onehot[k] = 1'b1;
      end else begin
        onehot[k] = 1'b0;
      end
    end
    return onehot;
  endfunction

endpackage

// File: rtl/dl_pipe_reg.sv
// dl_pipe_reg
// One-entry valid/ready register. Loads when empty, or when full and the
// held beat drains in the same cycle, giving full throughput.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   in_valid/in_ready  - upstream handshake (in_ready never looks at in_valid)
//   in_data            - upstream payload
//   out_valid/out_ready- downstream handshake
//   out_data           - held payload, straight from the register
module dl_pipe_reg #(
  parameter int NUM_BITS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] out_data
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]          state_r;
  logic [0:0]          state_s;
  logic [NUM_BITS-1:0] data_r;
  logic                load_s;

  assign in_ready  = (state_r == ST_EMPTY) || out_ready;
  assign load_s    = in_valid && in_ready;
  assign out_valid = (state_r == ST_FULL);
  assign out_data  = data_r;

  // Next occupancy: a full entry stays full if reloaded or not drained.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (load_s) begin
          state_s = ST_FULL;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (load_s || !out_ready) begin
          state_s = ST_FULL;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      default: state_s = ST_EMPTY;
    endcase
  end

  // Occupancy and payload registers; reset discards any held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
      data_r  <= {NUM_BITS{1'b0}};
    end else begin
      state_r <= state_s;
      if (load_s) begin
        data_r <= in_data;
      end else begin
        data_r <= data_r;
      end
    end
  end

endmodule

// File: rtl/dl_demux5_stream.sv
// dl_demux5_stream
// Registered 1-to-5 valid/ready stream demultiplexer. Each accepted beat is
// steered by in_sel into one of five independent one-entry channel registers.
// Optional feature macro: DL_DEMUX5_ERR_EN
//   undefined - selects 5..7 route to channel 0 (mux default arm)
//   defined   - selects 5..7 are accepted and dropped; a sticky err flag and
//               the first offending select are kept until err_clr
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   in_valid/in_ready       - input handshake; in_ready = can-load of the
//                             selected channel
//   in_sel, in_data         - destination channel and payload
//   out_valid[4:0]          - per-channel valid
//   out_ready[4:0]          - per-channel consumer ready
//   out0_data..out4_data    - per-channel payloads
//   err, err_sel, err_clr   - invalid-select capture (DL_DEMUX5_ERR_EN only)
module dl_demux5_stream
  import dl_demux_pkg::*;
#(
  parameter int NUM_BITS = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef DL_DEMUX5_ERR_EN
  output logic                        err,
  output logic [DL_DEMUX5_SEL_W-1:0]  err_sel,
  input  logic                        err_clr,
`endif
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DL_DEMUX5_SEL_W-1:0]  in_sel,
  input  logic [NUM_BITS-1:0]         in_data,
  output logic [DL_DEMUX5_NUM_CH-1:0] out_valid,
  input  logic [DL_DEMUX5_NUM_CH-1:0] out_ready,
  output logic [NUM_BITS-1:0]         out0_data,
  output logic [NUM_BITS-1:0]         out1_data,
  output logic [NUM_BITS-1:0]         out2_data,
  output logic [NUM_BITS-1:0]         out3_data,
  output logic [NUM_BITS-1:0]         out4_data
);

  dl_demux5_vec_t      dec_s;
  dl_demux5_vec_t      route_s;
  dl_demux5_vec_t      ch_in_valid_s;
  dl_demux5_vec_t      ch_ready_s;
  logic [NUM_BITS-1:0] ch_data_s [DL_DEMUX5_NUM_CH];

  // Select decode; an out-of-range select either falls back to channel 0
  // or, with error capture, routes nowhere so the beat is dropped.
  always_comb begin
    dec_s = dl_sel_to_onehot(in_sel);
    if (dec_s != 5'b00000) begin
      route_s = dec_s;
    end else begin
`ifdef DL_DEMUX5_ERR_EN
      route_s = 5'b00000;
`else
      route_s = 5'b00001;
`endif
    end
    ch_in_valid_s = {DL_DEMUX5_NUM_CH{in_valid}} & route_s;
  end

  // in_ready mux: only in_sel and the channel can-load terms feed it.
  always_comb begin
    case (in_sel)
      3'd0:    in_ready = ch_ready_s[0];
      3'd1:    in_ready = ch_ready_s[1];
      3'd2:    in_ready = ch_ready_s[2];
      3'd3:    in_ready = ch_ready_s[3];
      3'd4:    in_ready = ch_ready_s[4];
`ifdef DL_DEMUX5_ERR_EN
      default: in_ready = 1'b1;
`else
      default: in_ready = ch_ready_s[0];
`endif
    endcase
  end

  for (genvar k = 0; k < DL_DEMUX5_NUM_CH; k++) begin : g_ch
    dl_pipe_reg #(
      .NUM_BITS (NUM_BITS)
    ) u_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (ch_in_valid_s[k]),
      .in_ready  (ch_ready_s[k]),
      .in_data   (in_data),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_data  (ch_data_s[k])
    );
  end

  assign out0_data = ch_data_s[0];
  assign out1_data = ch_data_s[1];
  assign out2_data = ch_data_s[2];
  assign out3_data = ch_data_s[3];
  assign out4_data = ch_data_s[4];

`ifdef DL_DEMUX5_ERR_EN
  logic                       err_r;
  logic [DL_DEMUX5_SEL_W-1:0] err_sel_r;
  logic                       bad_beat_s;

  // An invalid beat is always accepted, so no in_ready term is needed.
  assign bad_beat_s = in_valid && (dec_s == 5'b00000);

  // Sticky capture of the first invalid select; a new invalid beat in the
  // same cycle as err_clr wins and records its own select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r     <= 1'b0;
      err_sel_r <= 3'd0;
    end else if (bad_beat_s && (!err_r || err_clr)) begin
      err_r     <= 1'b1;
      err_sel_r <= in_sel;
    end else if (err_clr) begin
      err_r     <= 1'b0;
      err_sel_r <= 3'd0;
    end else begin
      err_r     <= err_r;
      err_sel_r <= err_sel_r;
    end
  end

  assign err     = err_r;
  assign err_sel = err_sel_r;
`endif

endmodule

// File: tb/tb_dl_demux5_stream.sv
module tb_dl_demux5_stream;

  localparam int W   = 32;
  localparam int NCH = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_sel;
  logic [W-1:0]  in_data;
  logic [4:0]    out_valid;
  logic [4:0]    out_ready;
  logic [W-1:0]  out0_data, out1_data, out2_data, out3_data, out4_data;
`ifdef DL_DEMUX5_ERR_EN
  logic          err;
  logic [2:0]    err_sel;
  logic          err_clr;
`endif

  int n_checks;
  int n_errors;

  logic [W-1:0] sbq [NCH][$];

  typedef struct {
    logic         v;
    logic [2:0]   sel;
    logic [W-1:0] data;
    logic [4:0]   ordy;
    logic         exp_rdy;
    logic [4:0]   exp_ov;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  dl_demux5_stream #(.NUM_BITS(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef DL_DEMUX5_ERR_EN
    .err       (err),
    .err_sel   (err_sel),
    .err_clr   (err_clr),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0_data (out0_data),
    .out1_data (out1_data),
    .out2_data (out2_data),
    .out3_data (out3_data),
    .out4_data (out4_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] chan_data(input int k);
    case (k)
      0: return out0_data;
      1: return out1_data;
      2: return out2_data;
      3: return out3_data;
      default: return out4_data;
    endcase
  endfunction

  // Reference routing: -1 means the beat is dropped.
  function automatic int dest(input logic [2:0] s);
    if (s < 3'd5) return int'(s);
`ifdef DL_DEMUX5_ERR_EN
    return -1;
`else
    return 0;
`endif
  endfunction

  // One cycle: drive at negedge, check handshake/state against the model,
  // pop delivered beats, push accepted beats, then wait for the edge.
  task automatic drive(input logic v, input logic [2:0] s, input logic [W-1:0] d,
                       input logic [4:0] r, output logic obs_rdy, output logic [4:0] obs_ov);
    logic       exp_rdy;
    logic [4:0] exp_ov;
    int         dst;
    logic [W-1:0] exp_d;
    @(negedge clk);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
    dst = dest(s);
    for (int k = 0; k < NCH; k++) exp_ov[k] = (sbq[k].size() != 0);
    if (dst < 0) exp_rdy = 1'b1;
    else exp_rdy = (sbq[dst].size() == 0) || r[dst];
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    check("out_valid", {27'd0, out_valid}, {27'd0, exp_ov});
    obs_rdy = in_ready;
    obs_ov  = out_valid;
    for (int k = 0; k < NCH; k++) begin
      if (out_valid[k] && r[k]) begin
        if (sbq[k].size() == 0) begin
          check($sformatf("spurious_ch%0d", k), chan_data(k), 32'hxxxx_xxxx);
        end else begin
          exp_d = sbq[k].pop_front();
          check($sformatf("data_ch%0d", k), chan_data(k), exp_d);
        end
      end
    end
    if (v && in_ready && dst >= 0) sbq[dst].push_back(d);
    @(posedge clk);
  endtask

  logic       rdy_o;
  logic [4:0] ov_o;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 3'd0;
    in_data   = 32'd0;
    out_ready = 5'b00000;
`ifdef DL_DEMUX5_ERR_EN
    err_clr   = 1'b0;
`endif

    vecs[0]  = '{1'b1, 3'd2, 32'hA5A5_0002, 5'h1F, 1'b1, 5'b00000};
    vecs[1]  = '{1'b1, 3'd2, 32'hA5A5_0012, 5'h1F, 1'b1, 5'b00100};
    vecs[2]  = '{1'b0, 3'd2, 32'h0000_0000, 5'h1F, 1'b1, 5'b00100};
    vecs[3]  = '{1'b0, 3'd0, 32'h0000_0000, 5'h1F, 1'b1, 5'b00000};
    vecs[4]  = '{1'b1, 3'd3, 32'h3333_0001, 5'h17, 1'b1, 5'b00000};
    vecs[5]  = '{1'b1, 3'd3, 32'h3333_0002, 5'h17, 1'b0, 5'b01000};
    vecs[6]  = '{1'b1, 3'd1, 32'h1111_0001, 5'h17, 1'b1, 5'b01000};
    vecs[7]  = '{1'b1, 3'd3, 32'h3333_0002, 5'h17, 1'b0, 5'b01010};
    vecs[8]  = '{1'b1, 3'd3, 32'h3333_0002, 5'h1F, 1'b1, 5'b01000};
    vecs[9]  = '{1'b0, 3'd3, 32'h0000_0000, 5'h1F, 1'b1, 5'b01000};
    vecs[10] = '{1'b0, 3'd0, 32'h0000_0000, 5'h1F, 1'b1, 5'b00000};
    vecs[11] = '{1'b1, 3'd6, 32'hDEAD_BEEF, 5'h00, 1'b1, 5'b00000};
`ifdef DL_DEMUX5_ERR_EN
    vecs[12] = '{1'b0, 3'd0, 32'h0000_0000, 5'h00, 1'b1, 5'b00000};
    vecs[13] = '{1'b0, 3'd0, 32'h0000_0000, 5'h1F, 1'b1, 5'b00000};
`else
    vecs[12] = '{1'b0, 3'd0, 32'h0000_0000, 5'h00, 1'b0, 5'b00001};
    vecs[13] = '{1'b0, 3'd0, 32'h0000_0000, 5'h1F, 1'b1, 5'b00001};
`endif

    // Reset then idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", {27'd0, out_valid}, 32'd0);
    for (int k = 0; k < NCH; k++) check($sformatf("rst_data%0d", k), chan_data(k), 32'd0);
`ifdef DL_DEMUX5_ERR_EN
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_sel", {29'd0, err_sel}, 32'd0);
`endif
    for (int s = 0; s < 8; s++) begin
      in_sel = 3'(s);
      #1;
      check($sformatf("rst_in_ready_sel%0d", s), {31'd0, in_ready}, 32'd1);
    end

    // Directed table: streaming, stall on ch3, invalid select.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].sel, vecs[i].data, vecs[i].ordy, rdy_o, ov_o);
      check($sformatf("vec%0d_in_ready", i), {31'd0, rdy_o}, {31'd0, vecs[i].exp_rdy});
      check($sformatf("vec%0d_out_valid", i), {27'd0, ov_o}, {27'd0, vecs[i].exp_ov});
    end

`ifdef DL_DEMUX5_ERR_EN
    // Sticky capture, later invalid beats ignored, clear, set-wins-over-clear.
    #1;
    check("err_set", {31'd0, err}, 32'd1);
    check("err_sel_first", {29'd0, err_sel}, 32'd6);
    drive(1'b1, 3'd7, 32'h7777_7777, 5'h1F, rdy_o, ov_o);
    #1;
    check("err_sel_kept", {29'd0, err_sel}, 32'd6);
    err_clr = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 5'h1F, rdy_o, ov_o);
    err_clr = 1'b0;
    #1;
    check("err_cleared", {31'd0, err}, 32'd0);
    err_clr = 1'b1;
    drive(1'b1, 3'd5, 32'h5555_5555, 5'h1F, rdy_o, ov_o);
    err_clr = 1'b0;
    #1;
    check("err_set_wins", {31'd0, err}, 32'd1);
    check("err_sel_new", {29'd0, err_sel}, 32'd5);
    err_clr = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 5'h1F, rdy_o, ov_o);
    err_clr = 1'b0;
`endif

    // Asynchronous reset while channels 0 and 4 are full.
    drive(1'b1, 3'd0, 32'hC0C0_0000, 5'h00, rdy_o, ov_o);
    drive(1'b1, 3'd4, 32'hC4C4_0004, 5'h00, rdy_o, ov_o);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_rst_full", {27'd0, out_valid}, 32'h11);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {27'd0, out_valid}, 32'd0);
    for (int k = 0; k < NCH; k++) sbq[k].delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) drive(1'b0, 3'd0, 32'd0, 5'h1F, rdy_o, ov_o);

    // Random traffic against the per-channel scoreboard.
    for (int c = 0; c < 10000; c++) begin
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 31)) | (($urandom_range(0, 1) == 1) ? 5'h1F : 5'h00),
            rdy_o, ov_o);
    end
    repeat (3) drive(1'b0, 3'd0, 32'd0, 5'h1F, rdy_o, ov_o);
    for (int k = 0; k < NCH; k++) check($sformatf("drained_ch%0d", k), sbq[k].size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
